// File: rtl/vdp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vdp_pkg : shared constants, mode encoding and decode helper for the VDP  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package vdp_pkg;

   // register bit positions
   localparam logic [2:0] R0_M3    = 3'd1;
   localparam logic [2:0] R1_BLANK = 3'd6;
   localparam logic [2:0] R1_IE    = 3'd5;
   localparam logic [2:0] R1_M1    = 3'd4;
   localparam logic [2:0] R1_M2    = 3'd3;
   localparam logic [2:0] R1_SIZE  = 3'd1;
   localparam logic [2:0] R1_MAG   = 3'd0;

   // status byte bit positions; S5 occupies [4:0]
   localparam logic [2:0] ST_F  = 3'd7;
   localparam logic [2:0] ST_5S = 3'd6;
   localparam logic [2:0] ST_C  = 3'd5;

   // table base shifts
   localparam int unsigned NAME_SHIFT  = 10;
   localparam int unsigned COLOR_SHIFT = 6;
   localparam int unsigned FONT_SHIFT  = 11;
   localparam int unsigned SATTR_SHIFT = 7;
   localparam int unsigned SPAT_SHIFT  = 11;
   localparam int unsigned G2_SHIFT    = 13;

   typedef enum logic [1:0] {
      MODE_TEXT = 2'd0,
      MODE_G1   = 2'd1,
      MODE_G2   = 2'd2,
      MODE_MC   = 2'd3
   } vdp_mode_e;

   // M1 beats M3 beats M2; no mode bit means Graphics I
   function automatic vdp_mode_e decode_mode(input logic m1, input logic m2, input logic m3);
      vdp_mode_e m;
      if (m1)      m = MODE_TEXT;
      else if (m3) m = MODE_G2;
      else if (m2) m = MODE_MC;
      else         m = MODE_G1;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_cpu_port_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vdp_cpu_port_if : Z80 I/O bus and VRAM CPU-port bus of the VDP front end |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface vdp_cpu_port_if #(
   parameter int ADDR_W = 14
);
   logic              cpu_sel;
   logic              cpu_wr;
   logic              cpu_rd;
   logic [7:0]        cpu_din;
   logic [7:0]        cpu_dout;
   logic [ADDR_W-1:0] vga_addr;
   logic [7:0]        vga_din;
   logic              vga_wr;
   logic              vga_rd;
   logic [7:0]        vga_dout;

   modport master (
      output cpu_sel, cpu_wr, cpu_rd, cpu_din, vga_dout,
      input  cpu_dout, vga_addr, vga_din, vga_wr, vga_rd
   );

   modport slave (
      input  cpu_sel, cpu_wr, cpu_rd, cpu_din, vga_dout,
      output cpu_dout, vga_addr, vga_din, vga_wr, vga_rd
   );
endinterface
`default_nettype wire

// File: rtl/vdp_status.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vdp_status : sticky F / 5S / C flags and S5 sprite number               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vdp_status
   import vdp_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       vblank_pulse,
   input  logic       sprite_collision,
   input  logic       too_many_sprites,
   input  logic [4:0] sprite5,
   input  logic       clr,
   output logic [7:0] status
);

   logic       f_q, f_d;
   logic       five_q, five_d;
   logic       coll_q, coll_d;
   logic [4:0] s5_q, s5_d;

   // a set event in the clearing cycle keeps its flag
   always_comb begin
      f_d    = vblank_pulse     | (f_q    & ~clr);
      five_d = too_many_sprites | (five_q & ~clr);
      coll_d = sprite_collision | (coll_q & ~clr);
      s5_d   = five_q ? s5_q : sprite5;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         f_q    <= 1'b0;
         five_q <= 1'b0;
         coll_q <= 1'b0;
         s5_q   <= 5'd0;
      end else begin
         f_q    <= f_d;
         five_q <= five_d;
         coll_q <= coll_d;
         s5_q   <= s5_d;
      end
   end

   always_comb begin
      status        = 8'h00;
      status[ST_F]  = f_q;
      status[ST_5S] = five_q;
      status[ST_C]  = coll_q;
      status[4:0]   = s5_q;
   end

endmodule
`default_nettype wire

// File: rtl/vdp_cpu_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vdp_cpu_port : CPU front end of the VDP - registers, VRAM address,       |
// | read-ahead buffer, status and interrupt. VDP_RDBUF_ON_WRITE_EN makes a   |
// | data write also load the read-ahead buffer.                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vdp_cpu_port
   import vdp_pkg::*;
#(
   parameter int         ADDR_W = 14,
   parameter logic [3:0] RST_BG = 4'h4
) (
   input  logic        clk,
   input  logic        reset,
   vdp_cpu_port_if.slave bus,
   output logic [1:0]  mode,
   output logic [13:0] name_table_addr,
   output logic [13:0] color_table_addr,
   output logic [13:0] font_addr,
   output logic [13:0] sprite_attr_addr,
   output logic [13:0] sprite_pattern_table_addr,
   output logic        video_on,
   output logic        vert_retrace_int,
   output logic        sprite_large,
   output logic        sprite_enlarged,
   output logic [3:0]  text_color,
   output logic [3:0]  back_color,
   input  logic        vblank_pulse,
   input  logic        sprite_collision,
   input  logic        too_many_sprites,
   input  logic [4:0]  sprite5,
   output logic        n_int
);

   localparam logic [7:0][7:0] REGS_RST = {{4'h0, RST_BG}, 56'h0};

   logic [7:0][7:0]   regs_q, regs_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        latch_q, latch_d;
   logic              latch_full_q, latch_full_d;
   logic [7:0]        rdbuf_q, rdbuf_d;
   logic [7:0]        cpu_dout_q, cpu_dout_d;
   logic [ADDR_W-1:0] vga_addr_q, vga_addr_d;
   logic [7:0]        vga_din_q, vga_din_d;
   logic              vga_wr_q, vga_wr_d;
   logic              vga_rd_q, vga_rd_d;
   logic              capture_q, capture_d;
   logic              status_clr;
   logic [7:0]        status;
   logic              acc_wr, acc_rd;
   vdp_mode_e         mode_e;
   logic              unused_bits;

   vdp_status u_status (
      .clk              (clk),
      .reset            (reset),
      .vblank_pulse     (vblank_pulse),
      .sprite_collision (sprite_collision),
      .too_many_sprites (too_many_sprites),
      .sprite5          (sprite5),
      .clr              (status_clr),
      .status           (status)
   );

   assign acc_wr = bus.cpu_wr;
   assign acc_rd = bus.cpu_rd & ~bus.cpu_wr;

   always_comb begin
      regs_d       = regs_q;
      addr_d       = addr_q;
      latch_d      = latch_q;
      latch_full_d = latch_full_q;
      rdbuf_d      = rdbuf_q;
      cpu_dout_d   = cpu_dout_q;
      vga_addr_d   = vga_addr_q;
      vga_din_d    = vga_din_q;
      vga_wr_d     = 1'b0;
      vga_rd_d     = 1'b0;
      capture_d    = vga_rd_q;
      status_clr   = 1'b0;

      if (capture_q) rdbuf_d = bus.vga_dout;

      if (acc_wr) begin
         if (bus.cpu_sel) begin
            if (!latch_full_q) begin
               latch_d      = bus.cpu_din;
               latch_full_d = 1'b1;
            end else begin
               latch_full_d = 1'b0;
               if (bus.cpu_din[7]) begin
                  regs_d[bus.cpu_din[2:0]] = latch_q;
               end else begin
                  addr_d = ADDR_W'({bus.cpu_din[5:0], latch_q});
                  if (!bus.cpu_din[6]) begin
                     vga_rd_d   = 1'b1;
                     vga_addr_d = addr_d;
                     addr_d     = addr_d + ADDR_W'(1);
                  end
               end
            end
         end else begin
            vga_wr_d     = 1'b1;
            vga_addr_d   = addr_q;
            vga_din_d    = bus.cpu_din;
            addr_d       = addr_q + ADDR_W'(1);
            latch_full_d = 1'b0;
`ifdef VDP_RDBUF_ON_WRITE_EN
            rdbuf_d      = bus.cpu_din;
`endif
         end
      end else if (acc_rd) begin
         latch_full_d = 1'b0;
         if (bus.cpu_sel) begin
            cpu_dout_d = status;
            status_clr = 1'b1;
         end else begin
            // a read two clocks after a read-ahead meets its capture cycle: forward it
            cpu_dout_d = capture_q ? bus.vga_dout : rdbuf_q;
            vga_rd_d   = 1'b1;
            vga_addr_d = addr_q;
            addr_d     = addr_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q       <= REGS_RST;
         addr_q       <= '0;
         latch_q      <= 8'h00;
         latch_full_q <= 1'b0;
         rdbuf_q      <= 8'h00;
         cpu_dout_q   <= 8'h00;
         vga_addr_q   <= '0;
         vga_din_q    <= 8'h00;
         vga_wr_q     <= 1'b0;
         vga_rd_q     <= 1'b0;
         capture_q    <= 1'b0;
      end else begin
         regs_q       <= regs_d;
         addr_q       <= addr_d;
         latch_q      <= latch_d;
         latch_full_q <= latch_full_d;
         rdbuf_q      <= rdbuf_d;
         cpu_dout_q   <= cpu_dout_d;
         vga_addr_q   <= vga_addr_d;
         vga_din_q    <= vga_din_d;
         vga_wr_q     <= vga_wr_d;
         vga_rd_q     <= vga_rd_d;
         capture_q    <= capture_d;
      end
   end

   assign bus.cpu_dout = cpu_dout_q;
   assign bus.vga_addr = vga_addr_q;
   assign bus.vga_din  = vga_din_q;
   assign bus.vga_wr   = vga_wr_q;
   assign bus.vga_rd   = vga_rd_q;

   assign mode_e = decode_mode(regs_q[1][R1_M1], regs_q[1][R1_M2], regs_q[0][R0_M3]);
   assign mode   = mode_e;

   assign video_on         = regs_q[1][R1_BLANK];
   assign vert_retrace_int = regs_q[1][R1_IE];
   assign sprite_large     = regs_q[1][R1_SIZE];
   assign sprite_enlarged  = regs_q[1][R1_MAG];
   assign text_color       = regs_q[7][7:4];
   assign back_color       = regs_q[7][3:0];

   assign name_table_addr           = {regs_q[2][3:0], {NAME_SHIFT{1'b0}}};
   assign sprite_attr_addr          = {regs_q[5][6:0], {SATTR_SHIFT{1'b0}}};
   assign sprite_pattern_table_addr = {regs_q[6][2:0], {SPAT_SHIFT{1'b0}}};

   // Graphics II uses only the top bit of the colour and pattern bases
   always_comb begin
      if (mode_e == MODE_G2) begin
         color_table_addr = {regs_q[3][7], {G2_SHIFT{1'b0}}};
         font_addr        = {regs_q[4][2], {G2_SHIFT{1'b0}}};
      end else begin
         color_table_addr = {regs_q[3], {COLOR_SHIFT{1'b0}}};
         font_addr        = {regs_q[4][2:0], {FONT_SHIFT{1'b0}}};
      end
   end

   assign n_int = ~(status[ST_F] & regs_q[1][R1_IE]);

   assign unused_bits = ^regs_q;

endmodule
`default_nettype wire

// File: tb/tb_vdp_cpu_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vdp_cpu_port : directed self-checking bench for vdp_cpu_port          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vdp_cpu_port;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  mode;
   logic [13:0] name_table_addr, color_table_addr, font_addr;
   logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
   logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
   logic [3:0]  text_color, back_color;
   logic        vblank_pulse = 1'b0;
   logic        sprite_collision = 1'b0;
   logic        too_many_sprites = 1'b0;
   logic [4:0]  sprite5 = 5'h0A;
   logic        n_int;
   bit   [7:0]  vram [16384];
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   vdp_cpu_port_if #(.ADDR_W(14)) bus ();

   vdp_cpu_port #(.ADDR_W(14), .RST_BG(4'h4)) dut (
      .clk                       (clk),
      .reset                     (reset),
      .bus                       (bus),
      .mode                      (mode),
      .name_table_addr           (name_table_addr),
      .color_table_addr          (color_table_addr),
      .font_addr                 (font_addr),
      .sprite_attr_addr          (sprite_attr_addr),
      .sprite_pattern_table_addr (sprite_pattern_table_addr),
      .video_on                  (video_on),
      .vert_retrace_int          (vert_retrace_int),
      .sprite_large              (sprite_large),
      .sprite_enlarged           (sprite_enlarged),
      .text_color                (text_color),
      .back_color                (back_color),
      .vblank_pulse              (vblank_pulse),
      .sprite_collision          (sprite_collision),
      .too_many_sprites          (too_many_sprites),
      .sprite5                   (sprite5),
      .n_int                     (n_int)
   );

   // VRAM with one-cycle read latency
   always @(posedge clk) begin
      if (bus.vga_wr) vram[bus.vga_addr] <= bus.vga_din;
      bus.vga_dout <= vram[bus.vga_addr];
   end

   task automatic cpu_write(input logic sel, input logic [7:0] d);
      @(negedge clk);
      bus.cpu_sel = sel; bus.cpu_din = d; bus.cpu_wr = 1'b1;
      @(negedge clk);
      bus.cpu_wr = 1'b0;
   endtask

   task automatic cpu_read(input logic sel);
      @(negedge clk);
      bus.cpu_sel = sel; bus.cpu_rd = 1'b1;
      @(negedge clk);
      bus.cpu_rd = 1'b0;
   endtask

   task automatic set_reg(input logic [2:0] r, input logic [7:0] v);
      cpu_write(1'b1, v);
      cpu_write(1'b1, {5'b10000, r});
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      n_vec++; if (bus.vga_wr !== 1'b0 || bus.vga_rd !== 1'b0) begin n_err++; $display("FAIL rst_vga: wr=%b rd=%b want 0 0", bus.vga_wr, bus.vga_rd); end
      n_vec++; if (bus.cpu_dout !== 8'h00) begin n_err++; $display("FAIL rst_dout: got %h want 00", bus.cpu_dout); end
      n_vec++; if (n_int !== 1'b1) begin n_err++; $display("FAIL rst_nint: got %b want 1", n_int); end
      n_vec++; if (back_color !== 4'h4 || text_color !== 4'h0) begin n_err++; $display("FAIL rst_r7: text=%h back=%h want 0 4", text_color, back_color); end
      n_vec++; if (mode !== 2'd1 || video_on !== 1'b0) begin n_err++; $display("FAIL rst_mode: mode=%0d von=%b want 1 0", mode, video_on); end
   endtask

   task automatic test_data_write;
      cpu_write(1'b1, 8'h00);
      cpu_write(1'b1, 8'h40);
      n_vec++; if (bus.vga_rd !== 1'b0) begin n_err++; $display("FAIL setaddr_nord: vga_rd=%b want 0", bus.vga_rd); end
      cpu_write(1'b0, 8'hAA);
      n_vec++; if ({bus.vga_wr, bus.vga_addr, bus.vga_din} !== {1'b1, 14'h0000, 8'hAA}) begin n_err++; $display("FAIL dw0: wr=%b addr=%h din=%h want 1 0000 aa", bus.vga_wr, bus.vga_addr, bus.vga_din); end
      @(negedge clk);
      n_vec++; if (bus.vga_wr !== 1'b0) begin n_err++; $display("FAIL dw0_pulse: vga_wr=%b want 0", bus.vga_wr); end
      cpu_write(1'b0, 8'h55);
      n_vec++; if ({bus.vga_wr, bus.vga_addr, bus.vga_din} !== {1'b1, 14'h0001, 8'h55}) begin n_err++; $display("FAIL dw1: wr=%b addr=%h din=%h want 1 0001 55", bus.vga_wr, bus.vga_addr, bus.vga_din); end
   endtask

   task automatic test_back_to_back;
      // write and read strobes together: the write wins, landing at 0x0002
      @(negedge clk);
      bus.cpu_sel = 1'b0; bus.cpu_din = 8'h77; bus.cpu_wr = 1'b1; bus.cpu_rd = 1'b1;
      @(negedge clk);
      bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
      n_vec++; if ({bus.vga_wr, bus.vga_rd, bus.vga_addr} !== {1'b1, 1'b0, 14'h0002}) begin n_err++; $display("FAIL wr_rd: wr=%b rd=%b addr=%h want 1 0 0002", bus.vga_wr, bus.vga_rd, bus.vga_addr); end
   endtask

   task automatic test_regs;
      set_reg(3'd1, 8'hE0);
      n_vec++; if ({video_on, vert_retrace_int, mode, sprite_large} !== {1'b1, 1'b1, 2'd1, 1'b0}) begin n_err++; $display("FAIL r1_e0: von=%b ie=%b mode=%0d size=%b want 1 1 1 0", video_on, vert_retrace_int, mode, sprite_large); end
      set_reg(3'd7, 8'h1E);
      n_vec++; if ({text_color, back_color} !== 8'h1E) begin n_err++; $display("FAIL r7: got %h%h want 1e", text_color, back_color); end
      set_reg(3'd2, 8'h0F);
      set_reg(3'd5, 8'h7F);
      set_reg(3'd6, 8'h07);
      n_vec++; if (name_table_addr !== 14'h3C00) begin n_err++; $display("FAIL name_addr: got %h want 3c00", name_table_addr); end
      n_vec++; if (sprite_attr_addr !== 14'h3F80) begin n_err++; $display("FAIL sattr_addr: got %h want 3f80", sprite_attr_addr); end
      n_vec++; if (sprite_pattern_table_addr !== 14'h3800) begin n_err++; $display("FAIL spat_addr: got %h want 3800", sprite_pattern_table_addr); end
      set_reg(3'd1, 8'h1B);
      n_vec++; if ({mode, sprite_large, sprite_enlarged} !== {2'd0, 1'b1, 1'b1}) begin n_err++; $display("FAIL r1_text: mode=%0d size=%b mag=%b want 0 1 1", mode, sprite_large, sprite_enlarged); end
      set_reg(3'd1, 8'h08);
      n_vec++; if (mode !== 2'd3) begin n_err++; $display("FAIL mode_mc: got %0d want 3", mode); end
   endtask

   task automatic test_mode2;
      set_reg(3'd0, 8'h02);
      set_reg(3'd1, 8'h00);
      set_reg(3'd3, 8'hFF);
      set_reg(3'd4, 8'h07);
      n_vec++; if (mode !== 2'd2) begin n_err++; $display("FAIL mode_g2: got %0d want 2", mode); end
      n_vec++; if (color_table_addr !== 14'h2000 || font_addr !== 14'h2000) begin n_err++; $display("FAIL g2_tables: color=%h font=%h want 2000 2000", color_table_addr, font_addr); end
      set_reg(3'd0, 8'h00);
      n_vec++; if (color_table_addr !== 14'h3FC0 || font_addr !== 14'h3800) begin n_err++; $display("FAIL g1_tables: color=%h font=%h want 3fc0 3800", color_table_addr, font_addr); end
   endtask

   task automatic test_read_ahead;
      cpu_write(1'b1, 8'h34);
      cpu_write(1'b1, 8'h52);
      cpu_write(1'b0, 8'h5A);
      cpu_write(1'b1, 8'h34);
      cpu_write(1'b1, 8'h12);
      n_vec++; if ({bus.vga_rd, bus.vga_addr} !== {1'b1, 14'h1234}) begin n_err++; $display("FAIL ra_issue: rd=%b addr=%h want 1 1234", bus.vga_rd, bus.vga_addr); end
      cpu_read(1'b0);
      n_vec++; if (bus.cpu_dout !== 8'h5A) begin n_err++; $display("FAIL ra_data_fast: got %h want 5a", bus.cpu_dout); end
      n_vec++; if ({bus.vga_rd, bus.vga_addr} !== {1'b1, 14'h1235}) begin n_err++; $display("FAIL ra_next: rd=%b addr=%h want 1 1235", bus.vga_rd, bus.vga_addr); end
      cpu_write(1'b1, 8'h34);
      cpu_write(1'b1, 8'h12);
      repeat (3) @(negedge clk);
      cpu_read(1'b0);
      n_vec++; if (bus.cpu_dout !== 8'h5A) begin n_err++; $display("FAIL ra_data_slow: got %h want 5a", bus.cpu_dout); end
   endtask

   task automatic test_status_irq;
      set_reg(3'd1, 8'h20);
      n_vec++; if (n_int !== 1'b1) begin n_err++; $display("FAIL irq_idle: n_int=%b want 1", n_int); end
      @(negedge clk); vblank_pulse = 1'b1;
      @(negedge clk); vblank_pulse = 1'b0;
      n_vec++; if (n_int !== 1'b0) begin n_err++; $display("FAIL irq_set: n_int=%b want 0", n_int); end
      cpu_read(1'b1);
      n_vec++; if (bus.cpu_dout !== 8'h8A) begin n_err++; $display("FAIL stat_f: got %h want 8a", bus.cpu_dout); end
      n_vec++; if (n_int !== 1'b1) begin n_err++; $display("FAIL irq_clr: n_int=%b want 1", n_int); end
      @(negedge clk);
      bus.cpu_sel = 1'b1; bus.cpu_rd = 1'b1; vblank_pulse = 1'b1;
      @(negedge clk);
      bus.cpu_rd = 1'b0; vblank_pulse = 1'b0;
      n_vec++; if (bus.cpu_dout !== 8'h0A) begin n_err++; $display("FAIL stat_race_dout: got %h want 0a", bus.cpu_dout); end
      n_vec++; if (n_int !== 1'b0) begin n_err++; $display("FAIL stat_race_f: n_int=%b want 0", n_int); end
      set_reg(3'd1, 8'h00);
      n_vec++; if (n_int !== 1'b1) begin n_err++; $display("FAIL ie_off: n_int=%b want 1", n_int); end
      set_reg(3'd1, 8'h20);
      n_vec++; if (n_int !== 1'b0) begin n_err++; $display("FAIL ie_on_fkept: n_int=%b want 0", n_int); end
      cpu_read(1'b1);
      n_vec++; if (bus.cpu_dout !== 8'h8A) begin n_err++; $display("FAIL stat_f2: got %h want 8a", bus.cpu_dout); end
      @(negedge clk); sprite_collision = 1'b1; too_many_sprites = 1'b1;
      @(negedge clk); sprite_collision = 1'b0; too_many_sprites = 1'b0; sprite5 = 5'h13;
      repeat (2) @(negedge clk);
      cpu_read(1'b1);
      n_vec++; if (bus.cpu_dout !== 8'h6A) begin n_err++; $display("FAIL stat_sticky: got %h want 6a", bus.cpu_dout); end
      cpu_read(1'b1);
      n_vec++; if (bus.cpu_dout !== 8'h13) begin n_err++; $display("FAIL stat_s5_follow: got %h want 13", bus.cpu_dout); end
   endtask

   task automatic test_wrap;
      logic [7:0] exp_rd;
`ifdef VDP_RDBUF_ON_WRITE_EN
      exp_rd = 8'hC3;
`else
      exp_rd = 8'h5A;
`endif
      cpu_write(1'b1, 8'h34);
      cpu_write(1'b1, 8'h12);
      repeat (3) @(negedge clk);
      cpu_write(1'b1, 8'hFF);
      cpu_write(1'b1, 8'h7F);
      cpu_write(1'b0, 8'hC3);
      n_vec++; if ({bus.vga_wr, bus.vga_addr, bus.vga_din} !== {1'b1, 14'h3FFF, 8'hC3}) begin n_err++; $display("FAIL wrap_wr: wr=%b addr=%h din=%h want 1 3fff c3", bus.vga_wr, bus.vga_addr, bus.vga_din); end
      cpu_read(1'b0);
      n_vec++; if ({bus.vga_rd, bus.vga_addr} !== {1'b1, 14'h0000}) begin n_err++; $display("FAIL wrap_addr: rd=%b addr=%h want 1 0000", bus.vga_rd, bus.vga_addr); end
      n_vec++; if (bus.cpu_dout !== exp_rd) begin n_err++; $display("FAIL wrap_rdbuf: got %h want %h", bus.cpu_dout, exp_rd); end
   endtask

   task automatic test_reset_midread;
      cpu_write(1'b1, 8'h34);
      cpu_write(1'b1, 8'h12);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_vec++; if ({text_color, back_color} !== 8'h04 || bus.cpu_dout !== 8'h00) begin n_err++; $display("FAIL rst2_regs: r7=%h%h dout=%h want 04 00", text_color, back_color, bus.cpu_dout); end
      cpu_read(1'b0);
      n_vec++; if (bus.cpu_dout !== 8'h00) begin n_err++; $display("FAIL rst2_drop: got %h want 00", bus.cpu_dout); end
   endtask

   initial begin
      bus.cpu_sel = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_din = 8'h00;
      test_reset;
      test_data_write;
      test_back_to_back;
      test_regs;
      test_mode2;
      test_read_ahead;
      test_status_irq;
      test_wrap;
      test_reset_midread;
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
